// File: rtl/usb_vf_stream_buffer_if.sv
// Pixel-stream input and UVC frame-fetch signals grouped for the stream buffer.
// master drives stimulus and consumer requests; slave is the buffer itself.
interface usb_vf_stream_buffer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sof;
    logic       vf_sof;
    logic       vf_req;
    logic [7:0] vf_byte;

    modport master (
        output in_valid, in_data, in_sof, vf_sof, vf_req,
        input  vf_byte
    );

    modport slave (
        input  in_valid, in_data, in_sof, vf_sof, vf_req,
        output vf_byte
    );
endinterface

// File: rtl/usb_vf_stream_buffer.sv
// Buffers a non-stallable pixel stream and serves FRAME_BYTES per host frame; vf_byte updates the cycle after vf_req.
// No backpressure: pixels arriving while full are dropped and counted, reads with no data return FILL_BYTE and are counted.
module usb_vf_stream_buffer #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          FRAME_BYTES = 30240,
    parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rstn,
    usb_vf_stream_buffer_if.slave bus,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           underflow_cnt,
    output logic [15:0]           overflow_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RW    = $clog2(FRAME_BYTES + 1);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH[DEPTH_LOG2:0];
    localparam logic [RW-1:0]         REM_ONE  = 1;
    localparam logic [RW-1:0]         REM_FULL = FRAME_BYTES[RW-1:0];

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_SEEK = 2'd1,
        R_RUN  = 2'd2,
        R_END  = 2'd3
    } rstate_e;

    logic [8:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    rstate_e               state_q, state_d;
    logic [RW-1:0]         remaining_q, remaining_d;
    logic [7:0]            vf_byte_q, vf_byte_d;
    logic [15:0]           underflow_q, underflow_d;
    logic [15:0]           overflow_q, overflow_d;

    logic       fifo_empty, fifo_full, push, pop, unf_inc;
    logic [8:0] head;
    logic       head_sof;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LVL_FULL);
    assign head       = mem_q[rd_ptr_q];
    assign head_sof   = head[8];
    assign push       = bus.in_valid && !fifo_full;

    // Storage needs no reset: occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_sof, bus.in_data};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + LVL_ONE;
        end else if (pop && !push) begin
            count_d = count_q - LVL_ONE;
        end
        if (bus.in_valid && fifo_full && (overflow_q != 16'hFFFF)) begin
            overflow_d = overflow_q + 16'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        vf_byte_d   = vf_byte_q;
        pop         = 1'b0;
        unf_inc     = 1'b0;
        if (bus.vf_sof) begin
            state_d     = R_SEEK;
            remaining_d = REM_FULL;
            vf_byte_d   = FILL_BYTE;
        end else begin
            case (state_q)
                R_IDLE, R_END: begin
                    vf_byte_d = FILL_BYTE;
                    if (!fifo_empty && !head_sof) begin
                        pop = 1'b1;
                    end
                end
                R_SEEK: begin
                    unf_inc = bus.vf_req;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head_sof) begin
                            vf_byte_d = head[7:0];
                            state_d   = R_RUN;
                        end
                    end
                end
                R_RUN: begin
                    if (bus.vf_req) begin
                        if (remaining_q == REM_ONE) begin
                            state_d   = R_END;
                            vf_byte_d = FILL_BYTE;
                        end else begin
                            remaining_d = remaining_q - REM_ONE;
                            // A new sof entry means the input frame ran short: pad, keep it for the next frame.
                            if (!fifo_empty && !head_sof) begin
                                vf_byte_d = head[7:0];
                                pop       = 1'b1;
                            end else begin
                                vf_byte_d = FILL_BYTE;
                                unf_inc   = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = R_IDLE;
            endcase
        end
        underflow_d = underflow_q;
        if (unf_inc && (underflow_q != 16'hFFFF)) begin
            underflow_d = underflow_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= R_IDLE;
            remaining_q <= '0;
            vf_byte_q   <= FILL_BYTE;
            underflow_q <= '0;
            overflow_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            vf_byte_q   <= vf_byte_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.vf_byte    = vf_byte_q;
    assign fifo_level     = count_q;
    assign underflow_cnt  = underflow_q;
    assign overflow_cnt   = overflow_q;
endmodule

// File: tb/tb_usb_vf_stream_buffer.sv
// Directed bench: issued requests queue their expected byte; a negedge monitor pops and compares.
module tb_usb_vf_stream_buffer;
    localparam int FB = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    usb_vf_stream_buffer_if m_if ();
    usb_vf_stream_buffer_if s_if ();

    logic [5:0]  m_lvl;
    logic [15:0] m_unf, m_ovf;
    logic [2:0]  s_lvl;
    logic [15:0] s_unf, s_ovf;

    usb_vf_stream_buffer #(.DEPTH_LOG2(5), .FRAME_BYTES(FB), .FILL_BYTE(8'h00)) dut (
        .clk(clk), .rstn(rstn), .bus(m_if),
        .fifo_level(m_lvl), .underflow_cnt(m_unf), .overflow_cnt(m_ovf)
    );

    usb_vf_stream_buffer #(.DEPTH_LOG2(2), .FRAME_BYTES(FB), .FILL_BYTE(8'h00)) dut_s (
        .clk(clk), .rstn(rstn), .bus(s_if),
        .fifo_level(s_lvl), .underflow_cnt(s_unf), .overflow_cnt(s_ovf)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic sof);
        m_if.in_valid = 1'b1;
        m_if.in_data  = d;
        m_if.in_sof   = sof;
        cyc(1);
        m_if.in_valid = 1'b0;
        m_if.in_sof   = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            push(first + 8'(i), (i == 0));
        end
    endtask

    task automatic req(input logic [7:0] e);
        exp_q.push_back(e);
        m_if.vf_req = 1'b1;
        cyc(1);
        m_if.vf_req = 1'b0;
    endtask

    task automatic req_run(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            req(first + 8'(i));
        end
    endtask

    task automatic frame_sof();
        m_if.vf_sof = 1'b1;
        cyc(1);
        m_if.vf_sof = 1'b0;
    endtask

    // Byte taken at the coming edge is the one on vf_byte now; vf_sof in the same cycle cancels the take.
    always @(negedge clk) begin
        if (rstn && m_if.vf_req && !m_if.vf_sof) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL consumed_byte: got 0x%0h with no byte expected", m_if.vf_byte);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_if.vf_byte !== mon_e) begin
                    errors++;
                    $display("FAIL consumed_byte: got 0x%0h, expected 0x%0h", m_if.vf_byte, mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        m_if.in_valid = 0; m_if.in_data = 0; m_if.in_sof = 0; m_if.vf_sof = 0; m_if.vf_req = 0;
        s_if.in_valid = 0; s_if.in_data = 0; s_if.in_sof = 0; s_if.vf_sof = 0; s_if.vf_req = 0;
        cyc(3);
        check("rst_vf_byte", m_if.vf_byte, 8'h00);
        check("rst_level", m_lvl, 0);
        check("rst_unf", m_unf, 0);
        check("rst_ovf", m_ovf, 0);
        check("rst_state", 2'(dut.state_q), 2'd0);
        rstn = 1'b1;
        cyc(1);

        // Overflow on the 4-entry instance while idle.
        for (int i = 0; i < 6; i++) begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = 8'hA0 + 8'(i);
            s_if.in_sof   = (i == 0);
            cyc(1);
        end
        s_if.in_valid = 1'b0;
        s_if.in_sof   = 1'b0;
        check("ovf_level", s_lvl, 4);
        check("ovf_cnt", s_ovf, 2);
        s_if.vf_sof = 1'b1;
        cyc(1);
        s_if.vf_sof = 1'b0;
        cyc(1);
        check("ovf_head_sof_byte", s_if.vf_byte, 8'hA0);

        // Full frame, one extra request lands in R_END.
        push_frame(8'h10, 8);
        check("t1_level", m_lvl, 8);
        frame_sof();
        cyc(1);
        check("t1_first_load", m_if.vf_byte, 8'h10);
        req_run(8'h10, 8);
        req(8'h00);
        check("t1_state_end", 2'(dut.state_q), 2'd3);
        check("t1_vf_fill", m_if.vf_byte, 8'h00);
        check("t1_unf", m_unf, 0);
        check("t1_ovf", m_ovf, 0);
        check("t1_level_empty", m_lvl, 0);

        // Requests while seeking on an empty FIFO.
        frame_sof();
        req(8'h00); req(8'h00); req(8'h00);
        check("t2_unf", m_unf, 3);
        push(8'h20, 1'b1);
        check("t2_not_yet", m_if.vf_byte, 8'h00);
        push(8'h21, 1'b0);
        check("t2_seek_load", m_if.vf_byte, 8'h20);
        for (int i = 2; i < 8; i++) push(8'h20 + 8'(i), 1'b0);
        check("t2_level", m_lvl, 7);
        req_run(8'h20, 8);
        check("t2_unf_after", m_unf, 3);

        // Short input frame followed by the next sof frame.
        push_frame(8'h10, 5);
        push_frame(8'h30, 8);
        frame_sof();
        cyc(1);
        check("t4_first_load", m_if.vf_byte, 8'h10);
        req_run(8'h10, 5);
        req(8'h00); req(8'h00); req(8'h00);
        check("t4_unf", m_unf, 6);
        check("t4_level", m_lvl, 8);
        check("t4_state_end", 2'(dut.state_q), 2'd3);
        frame_sof();
        cyc(1);
        check("t4_next_load", m_if.vf_byte, 8'h30);
        check("t4_no_discard", m_lvl, 7);
        req_run(8'h30, 8);

        // Long input frame: two leftovers discarded in R_END.
        push_frame(8'h40, 10);
        push(8'h50, 1'b1);
        check("t5_level", m_lvl, 11);
        frame_sof();
        cyc(1);
        req_run(8'h40, 8);
        cyc(3);
        check("t5_leftover_drained", m_lvl, 1);
        frame_sof();
        cyc(1);
        check("t5_next_load", m_if.vf_byte, 8'h50);
        check("t5_level_empty", m_lvl, 0);
        check("t5_unf", m_unf, 6);

        // vf_sof and vf_req together from R_RUN.
        m_if.vf_sof = 1'b1;
        m_if.vf_req = 1'b1;
        cyc(1);
        m_if.vf_sof = 1'b0;
        m_if.vf_req = 1'b0;
        check("sim_state_seek", 2'(dut.state_q), 2'd1);
        check("sim_remaining", 32'(dut.remaining_q), FB);
        check("sim_vf_fill", m_if.vf_byte, 8'h00);
        check("sim_unf", m_unf, 6);

        push(8'h60, 1'b1);
        push(8'h61, 1'b0);
        check("t6_load", m_if.vf_byte, 8'h60);
        push(8'h62, 1'b0);
        req(8'h60); req(8'h61);
        check("t6_state_run", 2'(dut.state_q), 2'd2);

        // Asynchronous reset mid-frame, observed before any clock edge.
        rstn = 1'b0;
        #1;
        check("arst_vf_byte", m_if.vf_byte, 8'h00);
        check("arst_level", m_lvl, 0);
        check("arst_unf", m_unf, 0);
        check("arst_ovf", s_ovf, 0);
        check("arst_state", 2'(dut.state_q), 2'd0);
        cyc(2);
        rstn = 1'b1;
        cyc(1);

        push(8'h70, 1'b0);
        cyc(1);
        check("post_rst_discard", m_lvl, 0);
        frame_sof();
        push(8'h80, 1'b1);
        push(8'h81, 1'b0);
        check("post_rst_realign", m_if.vf_byte, 8'h80);

        cyc(2);
        check("expected_all_consumed", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
